// File: rtl/regfile_access_ctrl_if.sv
// rtl/regfile_access_ctrl_if.sv - decode, writeback and register-file signals of the access controller
interface regfile_access_ctrl_if;
  // decode operand-read handshake
  logic        RdReq;
  logic [4:0]  RdAddrA;
  logic [4:0]  RdAddrB;
  logic        RdReady;
  logic        OpValid;
  logic [31:0] OpA;
  logic [31:0] OpB;
  // writeback handshake
  logic        WbReq;
  logic [4:0]  WbAddr;
  logic [31:0] WbData;
  logic        WbReady;
  // register-file request interface
  logic [4:0]  ReadAddr1;
  logic [4:0]  ReadAddr2;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  // controller side: initiator towards the regfile, target for decode/writeback
  modport master (
    input  RdReq, RdAddrA, RdAddrB, WbReq, WbAddr, WbData, ReadData1, ReadData2,
    output RdReady, OpValid, OpA, OpB, WbReady,
    output ReadAddr1, ReadAddr2, WriteAddr, WriteData, RegWrite
  );

  // environment side: decode, writeback and the register file itself
  modport slave (
    output RdReq, RdAddrA, RdAddrB, WbReq, WbAddr, WbData, ReadData1, ReadData2,
    input  RdReady, OpValid, OpA, OpB, WbReady,
    input  ReadAddr1, ReadAddr2, WriteAddr, WriteData, RegWrite
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - register-file access sequencer: buffered writes with priority, stalled reads, r0 forced to zero
module regfile_access_ctrl #(
  parameter int WB_DEPTH = 2,
  parameter int WB_AW    = 1
) (
  input  logic Clock,
  input  logic Reset_n,
  regfile_access_ctrl_if.master bus
);
  typedef enum logic {IDLE, CAPTURE} state_t;

  localparam logic [WB_AW:0] FullCount = (WB_AW+1)'(WB_DEPTH);

  logic [4:0]       fifoAddr [WB_DEPTH];
  logic [31:0]      fifoData [WB_DEPTH];
  logic [WB_AW-1:0] headPtr;
  logic [WB_AW-1:0] tailPtr;
  logic [WB_AW:0]   count;
  logic             empty;
  logic             full;
  logic             wbAccept;
  logic             push;
  logic             pop;

  state_t           state;
  logic [4:0]       latA;
  logic [4:0]       latB;
  logic             rdFire;

  assign empty = (count == '0);
  assign full  = (count == FullCount);

  // Writes to r0 are swallowed at the door so the regfile never sees them.
  assign bus.WbReady = !full;
  assign wbAccept    = bus.WbReq & !full;
  assign push        = wbAccept & (bus.WbAddr != 5'd0);
  assign pop         = !empty;

  // The head is presented whenever something is queued; the regfile takes it every such edge.
  assign bus.RegWrite  = !empty;
  assign bus.WriteAddr = empty ? 5'd0  : fifoAddr[headPtr];
  assign bus.WriteData = empty ? 32'd0 : fifoData[headPtr];

  // Reads only go out with no write queued or arriving, so a read can never overtake a write.
  assign bus.RdReady = Reset_n & (state == IDLE) & empty & !bus.WbReq;
  assign rdFire      = bus.RdReq & bus.RdReady;

  // On the handshake cycle the new addresses go straight to the regfile; otherwise hold the latched ones.
  assign bus.ReadAddr1 = rdFire ? bus.RdAddrA : latA;
  assign bus.ReadAddr2 = rdFire ? bus.RdAddrB : latB;

  // Writeback storage: payload only, occupancy is tracked by the pointer block.
  always_ff @(posedge Clock) begin
    if (push) begin
      fifoAddr[tailPtr] <= bus.WbAddr;
      fifoData[tailPtr] <= bus.WbData;
    end
  end

  // Writeback pointers and occupancy; a reset discards anything still queued.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + 1'b1;
      if (pop)  headPtr <= headPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Read sequencer: latch addresses on handshake, capture registered regfile data one cycle later.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      latA        <= 5'd0;
      latB        <= 5'd0;
      bus.OpValid <= 1'b0;
      bus.OpA     <= 32'd0;
      bus.OpB     <= 32'd0;
    end else begin
      bus.OpValid <= 1'b0;
      case (state)
        IDLE: begin
          if (rdFire) begin
            latA  <= bus.RdAddrA;
            latB  <= bus.RdAddrB;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          bus.OpA     <= (latA == 5'd0) ? 32'd0 : bus.ReadData1;
          bus.OpB     <= (latB == 5'd0) ? 32'd0 : bus.ReadData2;
          bus.OpValid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb/tb_regfile_access_ctrl.sv - directed bench with a transaction-level model for regfile_access_ctrl
module tb_regfile_access_ctrl;
  logic Clock;
  logic Reset_n;

  regfile_access_ctrl_if bus();

  regfile_access_ctrl #(.WB_DEPTH(2), .WB_AW(1)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  int nVec = 0;
  int nMis = 0;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [31:0] initVal(input logic [4:0] a);
    return 32'hC0DE_0000 | {27'd0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file: registered read on RegWrite=0 edges, write on RegWrite=1 edges.
  logic [31:0] rfMem [32];
  logic        rfWritten [32] = '{default: 1'b0};
  always @(posedge Clock) begin
    if (bus.RegWrite) begin
      rfMem[bus.WriteAddr]     <= bus.WriteData;
      rfWritten[bus.WriteAddr] <= 1'b1;
    end else begin
      bus.ReadData1 <= rfWritten[bus.ReadAddr1] ? rfMem[bus.ReadAddr1] : initVal(bus.ReadAddr1);
      bus.ReadData2 <= rfWritten[bus.ReadAddr2] ? rfMem[bus.ReadAddr2] : initVal(bus.ReadAddr2);
    end
  end

  // Transaction model: architectural registers, pending-write queue, one outstanding read.
  logic [31:0] arch [32];
  logic [4:0]  qA[$];
  logic [31:0] qD[$];
  logic        capPending = 1'b0;
  logic [31:0] pendA = '0, pendB = '0;
  logic [4:0]  mLatA = '0, mLatB = '0;
  logic        mOpValid = 1'b0;
  logic [31:0] mOpA = '0, mOpB = '0;

  initial for (int i = 0; i < 32; i++) arch[i] = initVal(5'(i));

  always @(negedge Clock) begin : compare
    logic hs;
    logic expRdReady;
    int   sz;
    if (!Reset_n) begin
      chk("m_rst_rdready", {31'd0, bus.RdReady}, 32'd0);
      chk("m_rst_wbready", {31'd0, bus.WbReady}, 32'd1);
      chk("m_rst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
      chk("m_rst_waddr", {27'd0, bus.WriteAddr}, 32'd0);
      chk("m_rst_wdata", bus.WriteData, 32'd0);
      chk("m_rst_raddr1", {27'd0, bus.ReadAddr1}, 32'd0);
      chk("m_rst_raddr2", {27'd0, bus.ReadAddr2}, 32'd0);
      chk("m_rst_opvalid", {31'd0, bus.OpValid}, 32'd0);
      chk("m_rst_opa", bus.OpA, 32'd0);
      chk("m_rst_opb", bus.OpB, 32'd0);
      qA.delete(); qD.delete();
      capPending = 1'b0; mLatA = '0; mLatB = '0;
      mOpValid = 1'b0; mOpA = '0; mOpB = '0;
    end else begin
      sz = qA.size();
      expRdReady = !capPending && (sz == 0) && !bus.WbReq;
      hs = bus.RdReq && expRdReady;
      chk("m_rdready", {31'd0, bus.RdReady}, {31'd0, expRdReady});
      chk("m_wbready", {31'd0, bus.WbReady}, {31'd0, sz < 2});
      chk("m_regwrite", {31'd0, bus.RegWrite}, {31'd0, sz > 0});
      if (sz > 0) begin
        chk("m_waddr", {27'd0, bus.WriteAddr}, {27'd0, qA[0]});
        chk("m_wdata", bus.WriteData, qD[0]);
      end
      chk("m_raddr1", {27'd0, bus.ReadAddr1}, {27'd0, hs ? bus.RdAddrA : mLatA});
      chk("m_raddr2", {27'd0, bus.ReadAddr2}, {27'd0, hs ? bus.RdAddrB : mLatB});
      chk("m_opvalid", {31'd0, bus.OpValid}, {31'd0, mOpValid});
      chk("m_opa", bus.OpA, mOpA);
      chk("m_opb", bus.OpB, mOpB);
      // advance to the state after the coming edge
      mOpValid = capPending;
      if (capPending) begin
        mOpA = pendA;
        mOpB = pendB;
      end
      if (sz > 0) begin
        arch[qA[0]] = qD[0];
        void'(qA.pop_front());
        void'(qD.pop_front());
      end
      if (bus.WbReq && sz < 2 && bus.WbAddr != 5'd0) begin
        qA.push_back(bus.WbAddr);
        qD.push_back(bus.WbData);
      end
      if (hs) begin
        pendA = (bus.RdAddrA == 5'd0) ? 32'd0 : arch[bus.RdAddrA];
        pendB = (bus.RdAddrB == 5'd0) ? 32'd0 : arch[bus.RdAddrB];
        mLatA = bus.RdAddrA;
        mLatB = bus.RdAddrB;
      end
      capPending = hs;
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Presents a write and holds WbReq until accepted; leaves WbReq high for back-to-back use.
  task automatic wbWrite(input logic [4:0] a, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    bus.WbReq = 1'b1; bus.WbAddr = a; bus.WbData = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (bus.WbReady) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("wb_accept_bound", {31'd0, ok}, 32'd1);
    step();
  endtask

  // Issues a read, checks the two-cycle latency and returns the captured operands.
  task automatic rdOp(input logic [4:0] a, input logic [4:0] b, output logic [31:0] oa, output logic [31:0] ob);
    logic ok;
    ok = 1'b0;
    bus.RdReq = 1'b1; bus.RdAddrA = a; bus.RdAddrB = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (bus.RdReady) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("rd_handshake_bound", {31'd0, ok}, 32'd1);
    step();
    bus.RdReq = 1'b0;
    @(negedge Clock);
    chk("rd_lat_t1_opvalid", {31'd0, bus.OpValid}, 32'd0);
    step();
    @(negedge Clock);
    chk("rd_lat_t2_opvalid", {31'd0, bus.OpValid}, 32'd1);
    oa = bus.OpA;
    ob = bus.OpB;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic ok;
    Reset_n = 1'b0;
    bus.RdReq = 1'b0; bus.RdAddrA = '0; bus.RdAddrB = '0;
    bus.WbReq = 1'b0; bus.WbAddr = '0; bus.WbData = '0;
    @(negedge Clock);
    chk("rst_wbready", {31'd0, bus.WbReady}, 32'd1);
    chk("rst_rdready", {31'd0, bus.RdReady}, 32'd0);
    repeat (2) step();
    Reset_n = 1'b1;
    step();

    // write r5 then read it with r0 as the second operand
    wbWrite(5'd5, 32'hDEADBEEF);
    bus.WbReq = 1'b0;
    @(negedge Clock);
    chk("w5_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    chk("w5_waddr", {27'd0, bus.WriteAddr}, 32'd5);
    chk("w5_wdata", bus.WriteData, 32'hDEADBEEF);
    repeat (2) step();
    rdOp(5'd5, 5'd0, ra, rb);
    chk("r5_opa", ra, 32'hDEADBEEF);
    chk("r5_opb", rb, 32'd0);
    step();

    // write to r0 is dropped; r0 reads as zero even though the regfile holds garbage there
    wbWrite(5'd0, 32'h1234);
    bus.WbReq = 1'b0;
    @(negedge Clock);
    chk("w0_no_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    step();
    rdOp(5'd0, 5'd5, ra, rb);
    chk("r0_opa", ra, 32'd0);
    chk("r0_opb", rb, 32'hDEADBEEF);
    step();

    // back-to-back writes with WbReq held
    wbWrite(5'd1, 32'd1);
    wbWrite(5'd2, 32'd2);
    wbWrite(5'd3, 32'd3);
    bus.WbReq = 1'b0;
    repeat (2) step();
    rdOp(5'd1, 5'd2, ra, rb);
    chk("r1_opa", ra, 32'd1);
    chk("r2_opb", rb, 32'd2);
    step();
    rdOp(5'd3, 5'd0, ra, rb);
    chk("r3_opa", ra, 32'd3);
    step();

    // simultaneous read and write of r7: write wins, read sees the new value
    bus.RdReq = 1'b1; bus.RdAddrA = 5'd7; bus.RdAddrB = 5'd0;
    bus.WbReq = 1'b1; bus.WbAddr = 5'd7; bus.WbData = 32'h55;
    @(negedge Clock);
    chk("sim_rdready_low", {31'd0, bus.RdReady}, 32'd0);
    chk("sim_wbready", {31'd0, bus.WbReady}, 32'd1);
    step();
    bus.WbReq = 1'b0;
    @(negedge Clock);
    chk("sim_rdready_pending", {31'd0, bus.RdReady}, 32'd0);
    step();
    rdOp(5'd7, 5'd0, ra, rb);
    chk("r7_opa", ra, 32'h55);
    step();

    // preload r4/r6 then stream reads continuously
    wbWrite(5'd4, 32'hA);
    wbWrite(5'd6, 32'hB);
    bus.WbReq = 1'b0;
    repeat (2) step();
    bus.RdReq = 1'b1; bus.RdAddrA = 5'd4; bus.RdAddrB = 5'd6;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (bus.RdReady) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("stream_start_bound", {31'd0, ok}, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      step();
      @(negedge Clock);
      chk("stream_opvalid", {31'd0, bus.OpValid}, {31'd0, (k % 2) == 0});
      if ((k % 2) == 0) begin
        chk("stream_opa", bus.OpA, 32'hA);
        chk("stream_opb", bus.OpB, 32'hB);
      end
    end
    step();
    bus.RdReq = 1'b0;
    repeat (2) step();

    // reset in the CAPTURE cycle with a write arriving: nothing survives
    bus.RdReq = 1'b1; bus.RdAddrA = 5'd3; bus.RdAddrB = 5'd3;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (bus.RdReady) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("rstcap_handshake_bound", {31'd0, ok}, 32'd1);
    step();
    bus.RdReq = 1'b0;
    bus.WbReq = 1'b1; bus.WbAddr = 5'd8; bus.WbData = 32'h88;
    Reset_n = 1'b0;
    @(negedge Clock);
    chk("rstcap_opvalid", {31'd0, bus.OpValid}, 32'd0);
    chk("rstcap_rdready", {31'd0, bus.RdReady}, 32'd0);
    step();
    bus.WbReq = 1'b0;
    Reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      chk("rstcap_post_opvalid", {31'd0, bus.OpValid}, 32'd0);
      chk("rstcap_post_regwrite", {31'd0, bus.RegWrite}, 32'd0);
      step();
    end

    // reset with a write queued: it is lost, r9 keeps its old contents
    wbWrite(5'd9, 32'h99);
    bus.WbReq = 1'b0;
    Reset_n = 1'b0;
    @(negedge Clock);
    chk("rstq_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    step();
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("rstq_post_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    step();
    rdOp(5'd9, 5'd0, ra, rb);
    chk("rstq_r9_opa", ra, 32'hC0DE_0009);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
